// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ready + rvalid handshake
// and feeds IF/ID. Optional performance counters are enabled with `define IF_FETCH_PERF_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        Branch_Control,
  input  logic [31:0] Branch_Target,
  input  logic        Jump_Control,
  input  logic [31:0] Jump_Target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_out,
  output logic [31:0] PC_out,
  output logic        Valid_out
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] buf_reg;

  logic        redirect;
  logic [31:0] redirect_target;
  logic        accept;
  logic [31:0] pc_inc;
  logic        present_mem;
  logic        present_buf;
  logic        present;
  logic [31:0] present_data;

  // Branch wins over jump when both are decoded in the same cycle.
  assign redirect        = Branch_Control | Jump_Control;
  assign redirect_target = Branch_Control ? Branch_Target : Jump_Target;

  assign accept       = (state_reg == S_REQ) && imem_req && imem_ready;
  assign pc_inc       = pc_reg + 32'd4;
  assign present_mem  = (state_reg == S_WAIT) && imem_rvalid && !stall && !redirect;
  assign present_buf  = (state_reg == S_HOLD) && !stall && !redirect;
  assign present      = present_mem | present_buf;
  assign present_data = present_buf ? buf_reg : imem_rdata;

  assign imem_addr = pc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_REQ;
      pc_reg          <= RESET_PC;
      buf_reg         <= NOP_INSTR;
      imem_req        <= 1'b0;
      Instruction_out <= NOP_INSTR;
      PC_out          <= RESET_PC;
      Valid_out       <= 1'b0;
    end else begin
      // IF/ID-facing registers: frozen under stall unless a redirect flushes them.
      if (redirect) begin
        Instruction_out <= NOP_INSTR;
        Valid_out       <= 1'b0;
        buf_reg         <= NOP_INSTR;
      end else if (present) begin
        Instruction_out <= present_data;
        PC_out          <= pc_inc;
        Valid_out       <= 1'b1;
      end else if (!stall) begin
        Instruction_out <= NOP_INSTR;
        Valid_out       <= 1'b0;
      end

      case (state_reg)
        S_REQ: begin
          if (redirect) begin
            pc_reg <= redirect_target;
            // A request accepted this cycle still owes a response that must be drained.
            if (accept) begin
              state_reg <= S_DRAIN;
              imem_req  <= 1'b0;
            end else begin
              state_reg <= S_REQ;
              imem_req  <= 1'b1;
            end
          end else if (accept) begin
            state_reg <= S_WAIT;
            imem_req  <= 1'b0;
          end else begin
            imem_req <= 1'b1;
          end
        end

        S_WAIT: begin
          if (redirect) begin
            pc_reg <= redirect_target;
            if (imem_rvalid) begin
              state_reg <= S_REQ;
              imem_req  <= 1'b1;
            end else begin
              state_reg <= S_DRAIN;
            end
          end else if (imem_rvalid) begin
            if (stall) begin
              buf_reg   <= imem_rdata;
              state_reg <= S_HOLD;
            end else begin
              pc_reg    <= pc_inc;
              state_reg <= S_REQ;
              imem_req  <= 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (redirect) begin
            pc_reg    <= redirect_target;
            state_reg <= S_REQ;
            imem_req  <= 1'b1;
          end else if (!stall) begin
            pc_reg    <= pc_inc;
            state_reg <= S_REQ;
            imem_req  <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (redirect) begin
            pc_reg <= redirect_target;
          end
          // Leaving on the stale response avoids waiting for one that will never come.
          if (imem_rvalid) begin
            state_reg <= S_REQ;
            imem_req  <= 1'b1;
          end
        end

        default: begin
          state_reg <= S_REQ;
          imem_req  <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt  <= 32'd0;
      perf_bubble_cnt <= 32'd0;
    end else begin
      if (present) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (!stall && !present) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: behavioural memory with adjustable latency and a
// scoreboard of expected presented instructions checked on every new IF/ID load.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        Branch_Control = 1'b0;
  logic [31:0] Branch_Target = 32'd0;
  logic        Jump_Control = 1'b0;
  logic [31:0] Jump_Target = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] Instruction_out;
  logic [31:0] PC_out;
  logic        Valid_out;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  if_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .Branch_Control (Branch_Control),
    .Branch_Target  (Branch_Target),
    .Jump_Control   (Jump_Control),
    .Jump_Target    (Jump_Target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .Instruction_out(Instruction_out),
    .PC_out         (PC_out),
    .Valid_out      (Valid_out)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int n_present = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;
  pend_t pend_q[$];
  int unsigned cyc = 0;
  int unsigned mem_lat = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h2008_0005;
      32'h0000_0004: mem_word = 32'hAC09_0010;
      default:       mem_word = ~a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Memory: one in-order response per accepted request, mem_lat edges later.
  always @(posedge clk) begin
    if (imem_rvalid && pend_q.size() > 0) void'(pend_q.pop_front());
    if (imem_req && imem_ready) pend_q.push_back('{imem_addr, cyc + mem_lat});
    #1;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    cyc = cyc + 1;
  end

  // A new instruction is loaded when Valid_out is high after an unstalled edge.
  logic stall_prev = 1'b0;
  always @(posedge clk) begin
    stall_prev = stall;
    #2;
    if (reset && Valid_out && !stall_prev) begin
      n_present++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_fetch: observed instr %h pc %h, expected no fetch", Instruction_out, PC_out);
        end
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("present_instr", Instruction_out, e.instr);
        chk("present_pc", PC_out, e.pc);
        $display("fetch: instr=%h pc_out=%h", Instruction_out, PC_out);
      end
    end
  end

  task automatic wait_req(input string tag);
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      if (imem_req === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    assert (got) else begin
      n_fail++;
      $error("FAIL timeout_req_%s: observed no request, expected imem_req=1", tag);
    end
  endtask

  task automatic wait_present(input string tag);
    int start = n_present;
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (n_present != start) begin
        got = 1;
        break;
      end
    end
    n_cmp++;
    assert (got) else begin
      n_fail++;
      $error("FAIL timeout_present_%s: observed no fetch, expected one", tag);
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_instr", Instruction_out, NOP);
    chk("rst_pc_out", PC_out, 32'h0);
    chk("rst_valid", {31'b0, Valid_out}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    reset = 1'b1;

    // First fetch at RESET_PC, 1-cycle memory
    wait_req("first");
    chk("addr_first", imem_addr, 32'h0);
    exp_q.push_back('{32'h2008_0005, 32'h4});
    wait_present("first");
    wait_req("second");
    chk("addr_second", imem_addr, 32'h4);

    // Stall while waiting for data: outputs frozen, data kept
    @(negedge clk);
    chk("in_wait", {31'b0, imem_req}, 32'd0);
    stall = 1'b1;
    exp_q.push_back('{32'hAC09_0010, 32'h8});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("frozen_instr", Instruction_out, NOP);
      chk("frozen_pc", PC_out, 32'h4);
      chk("frozen_valid", {31'b0, Valid_out}, 32'd0);
    end
    stall = 1'b0;
    wait_present("held");
    wait_req("after_hold");
    chk("addr_after_hold", imem_addr, 32'h8);

    // Branch while in WAIT with slow memory: response drained and dropped
    mem_lat = 3;
    @(negedge clk);
    chk("wait_before_branch", {31'b0, imem_req}, 32'd0);
    Branch_Control = 1'b1;
    Branch_Target  = 32'h40;
    @(negedge clk);
    Branch_Control = 1'b0;
    chk("branch_instr", Instruction_out, NOP);
    chk("branch_valid", {31'b0, Valid_out}, 32'd0);
    chk("drain_no_req", {31'b0, imem_req}, 32'd0);
    wait_req("branch");
    chk("addr_branch", imem_addr, 32'h40);
    mem_lat = 1;
    exp_q.push_back('{~32'h40, 32'h44});
    wait_present("branch");

    // Branch and jump together during an accepted request: branch wins
    wait_req("seq44");
    chk("addr_seq44", imem_addr, 32'h44);
    Branch_Control = 1'b1;
    Branch_Target  = 32'h80;
    Jump_Control   = 1'b1;
    Jump_Target    = 32'h100;
    @(negedge clk);
    Branch_Control = 1'b0;
    Jump_Control   = 1'b0;
    chk("drain_after_accept", {31'b0, imem_req}, 32'd0);
    wait_req("prio");
    chk("addr_prio", imem_addr, 32'h80);
    exp_q.push_back('{~32'h80, 32'h84});
    wait_present("prio");

    // Jump while a request is not yet accepted
    wait_req("seq84");
    chk("addr_seq84", imem_addr, 32'h84);
    imem_ready   = 1'b0;
    Jump_Control = 1'b1;
    Jump_Target  = 32'h100;
    @(negedge clk);
    Jump_Control = 1'b0;
    imem_ready   = 1'b1;
    chk("jump_req", {31'b0, imem_req}, 32'd1);
    chk("addr_jump", imem_addr, 32'h100);
    exp_q.push_back('{~32'h100, 32'h104});
    wait_present("jump");

    // Asynchronous reset mid-WAIT
    wait_req("seq104");
    chk("addr_seq104", imem_addr, 32'h104);
    mem_lat = 3;
    @(negedge clk);
    chk("wait_before_reset", {31'b0, imem_req}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("arst_instr", Instruction_out, NOP);
    chk("arst_pc_out", PC_out, 32'h0);
    chk("arst_valid", {31'b0, Valid_out}, 32'd0);
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    repeat (5) @(negedge clk);
    reset   = 1'b1;
    mem_lat = 1;
    wait_req("restart");
    chk("addr_restart", imem_addr, 32'h0);
    exp_q.push_back('{32'h2008_0005, 32'h4});
    wait_present("restart");

    // PC wrap from 0xFFFFFFFC
    wait_req("seq4b");
    chk("addr_seq4b", imem_addr, 32'h4);
    imem_ready   = 1'b0;
    Jump_Control = 1'b1;
    Jump_Target  = 32'hFFFF_FFFC;
    @(negedge clk);
    Jump_Control = 1'b0;
    imem_ready   = 1'b1;
    chk("addr_top", imem_addr, 32'hFFFF_FFFC);
    exp_q.push_back('{32'h0000_0003, 32'h0});
    wait_present("wrap");
    wait_req("wrapped");
    chk("addr_wrapped", imem_addr, 32'h0);

    // Stall while a valid instruction is presented: it must stay put
    stall = 1'b1;
    exp_q.push_back('{32'h2008_0005, 32'h4});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, Valid_out}, 32'd1);
      chk("hold_instr", Instruction_out, 32'h0000_0003);
      chk("hold_pc", PC_out, 32'h0);
    end
    stall = 1'b0;
    wait_present("after_stall");
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
